// File: rtl/uart_mmio_pkg.sv
// Shared constants and FSM state types for the memory-mapped UART port.
package uart_mmio_pkg;

    localparam logic [1:0] ADDR_DATA   = 2'd0;
    localparam logic [1:0] ADDR_STATUS = 2'd1;
    localparam logic [1:0] ADDR_CTRL   = 2'd2;
    localparam logic [1:0] ADDR_ID     = 2'd3;

    localparam int unsigned ST_RX_EMPTY   = 0;
    localparam int unsigned ST_TX_FULL    = 1;
    localparam int unsigned ST_RX_OVERRUN = 2;
    localparam int unsigned ST_PARITY_ERR = 3;
    localparam int unsigned ST_TX_BUSY    = 4;

    localparam int unsigned CTRL_RXIE     = 0;
    localparam int unsigned CTRL_LOOPBACK = 1;

    localparam logic [6:0] UART_ID = 7'h52;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP
    } txState_t;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rxState_t;

    // Clocks per 16x oversample tick; never below one so the tick still fires.
    function automatic int unsigned baudDiv(input int unsigned clkFreq, input int unsigned baud);
        int unsigned d;
        d = clkFreq / (baud * 16);
        return (d == 0) ? 1 : d;
    endfunction

endpackage

// File: rtl/uart_mmio_port_sync_fifo.sv
// Synchronous FIFO used for both UART directions; a push into a full FIFO
// is accepted only when a pop happens in the same cycle.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wrPtr;
    logic [AW:0]      rdPtr;
    logic             doPush;
    logic             doPop;

    assign empty  = (wrPtr == rdPtr);
    assign full   = (wrPtr[AW] != rdPtr[AW]) && (wrPtr[AW-1:0] == rdPtr[AW-1:0]);
    assign doPop  = pop && !empty;
    assign doPush = push && (!full || doPop);
    assign head   = mem[rdPtr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (!rst) begin
            wrPtr <= '0;
            rdPtr <= '0;
        end else begin
            if (doPush) wrPtr <= wrPtr + (AW+1)'(1);
            if (doPop)  rdPtr <= rdPtr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (doPush) mem[wrPtr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/uart_mmio_port.sv
// Memory-mapped UART with TX/RX FIFOs, 16x oversampling and loopback.
// Optional even parity is enabled by defining UART_MMIO_PARITY_EN.
module uart_mmio_port
    import uart_mmio_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = 50000000,
    parameter int unsigned BAUD       = 19200,
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        addr,
    input  logic              wr,
    input  logic              rd,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    input  logic              rx,
    output logic              tx,
    output logic              irq
);

    localparam int unsigned DIV   = baudDiv(CLK_FREQ, BAUD);
    localparam int unsigned DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned BIT_W = $clog2(DATA_W);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);

    logic [DIV_W-1:0] baudCnt;
    logic             tick;

    logic rxie, loopback, rxOverrun, parityErr;
    logic dataWr, ctrlWr, dataRd, statusRd;

    logic              txPush, txPop, txFull, txEmpty;
    logic [DATA_W-1:0] txHead;
    logic              rxPush, rxPop, rxFull, rxEmpty, rxValid;
    logic [DATA_W-1:0] rxHead;
    logic              overrunSet, parErrSet;
    logic [DATA_W-1:0] statusVal, readMux;

    txState_t          txState, txStateN;
    logic [3:0]        txTick, txTickN;
    logic [BIT_W-1:0]  txBit, txBitN;
    logic [DATA_W-1:0] txShift, txShiftN;

    logic              rxSync1, rxSync2, rxPrev, rxFall;
    rxState_t          rxState, rxStateN;
    logic [3:0]        rxTick, rxTickN;
    logic [BIT_W-1:0]  rxBit, rxBitN;
    logic [DATA_W-1:0] rxShift, rxShiftN;
`ifdef UART_MMIO_PARITY_EN
    logic              txPar, txParN;
    logic              rxPar, rxParN;
`endif

    always_ff @(posedge clk) begin
        if (!rst) baudCnt <= '0;
        else if (tick) baudCnt <= '0;
        else baudCnt <= baudCnt + DIV_W'(1);
    end
    assign tick = (baudCnt == DIV_W'(DIV - 1));

    assign dataWr   = wr && (addr == ADDR_DATA);
    assign ctrlWr   = wr && (addr == ADDR_CTRL);
    assign dataRd   = rd && (addr == ADDR_DATA);
    assign statusRd = rd && (addr == ADDR_STATUS);

    assign txPush = dataWr && !txFull;
    assign rxPop  = dataRd && !rxEmpty;
    // A full RX FIFO still takes the character when a DATA read frees a slot.
    assign rxPush     = rxValid && (!rxFull || rxPop);
    assign overrunSet = rxValid && rxFull && !rxPop;
`ifdef UART_MMIO_PARITY_EN
    assign parErrSet  = rxValid && (rxPar != ^rxShift);
`else
    assign parErrSet  = 1'b0;
`endif

    sync_fifo #(.WIDTH(DATA_W), .DEPTH(FIFO_DEPTH)) txFifo (
        .clk(clk), .rst(rst), .push(txPush), .pop(txPop), .din(wdata),
        .full(txFull), .empty(txEmpty), .head(txHead)
    );

    sync_fifo #(.WIDTH(DATA_W), .DEPTH(FIFO_DEPTH)) rxFifo (
        .clk(clk), .rst(rst), .push(rxPush), .pop(rxPop), .din(rxShift),
        .full(rxFull), .empty(rxEmpty), .head(rxHead)
    );

    always_comb begin
        statusVal = '0;
        statusVal[ST_RX_EMPTY]   = rxEmpty;
        statusVal[ST_TX_FULL]    = txFull;
        statusVal[ST_RX_OVERRUN] = rxOverrun;
        statusVal[ST_PARITY_ERR] = parityErr;
        statusVal[ST_TX_BUSY]    = (txState != TX_IDLE) || !txEmpty;
    end

    always_comb begin
        readMux = '0;
        case (addr)
            ADDR_DATA:   readMux = rxEmpty ? '0 : rxHead;
            ADDR_STATUS: readMux = statusVal;
            ADDR_CTRL: begin
                readMux[CTRL_RXIE]     = rxie;
                readMux[CTRL_LOOPBACK] = loopback;
            end
            default:     readMux = DATA_W'(UART_ID);
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rdata     <= '0;
            rxie      <= 1'b0;
            loopback  <= 1'b0;
            rxOverrun <= 1'b0;
            parityErr <= 1'b0;
        end else begin
            if (rd) rdata <= readMux;
            if (ctrlWr) begin
                rxie     <= wdata[CTRL_RXIE];
                loopback <= wdata[CTRL_LOOPBACK];
            end
            rxOverrun <= (rxOverrun && !statusRd) || overrunSet;
            parityErr <= (parityErr && !statusRd) || parErrSet;
        end
    end

    assign irq = rxie && !rxEmpty;

    always_ff @(posedge clk) begin
        if (!rst) begin
            txState <= TX_IDLE;
            txTick  <= '0;
            txBit   <= '0;
            txShift <= '0;
`ifdef UART_MMIO_PARITY_EN
            txPar   <= 1'b0;
`endif
        end else begin
            txState <= txStateN;
            txTick  <= txTickN;
            txBit   <= txBitN;
            txShift <= txShiftN;
`ifdef UART_MMIO_PARITY_EN
            txPar   <= txParN;
`endif
        end
    end

    always_comb begin
        txStateN = txState;
        txTickN  = txTick;
        txBitN   = txBit;
        txShiftN = txShift;
        txPop    = 1'b0;
`ifdef UART_MMIO_PARITY_EN
        txParN   = txPar;
`endif
        if (txState == TX_IDLE) begin
            if (tick && !txEmpty) begin
                txPop    = 1'b1;
                txShiftN = txHead;
                txTickN  = '0;
                txBitN   = '0;
                txStateN = TX_START;
`ifdef UART_MMIO_PARITY_EN
                txParN   = ^txHead;
`endif
            end
        end else if (tick) begin
            txTickN = txTick + 4'd1;
            if (txTick == 4'd15) begin
                case (txState)
                    TX_START: txStateN = TX_DATA;
                    TX_DATA: begin
                        txShiftN = txShift >> 1;
                        txBitN   = txBit + BIT_W'(1);
                        if (txBit == LAST_BIT) begin
`ifdef UART_MMIO_PARITY_EN
                            txStateN = TX_PARITY;
`else
                            txStateN = TX_STOP;
`endif
                        end
                    end
                    TX_PARITY: txStateN = TX_STOP;
                    default:   txStateN = TX_IDLE;
                endcase
            end
        end
    end

    always_comb begin
        case (txState)
            TX_START:  tx = 1'b0;
            TX_DATA:   tx = txShift[0];
`ifdef UART_MMIO_PARITY_EN
            TX_PARITY: tx = txPar;
`endif
            default:   tx = 1'b1;
        endcase
    end

    // Loopback is muxed ahead of the synchronizer so both paths see identical timing.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rxSync1 <= 1'b1;
            rxSync2 <= 1'b1;
            rxPrev  <= 1'b1;
        end else begin
            rxSync1 <= loopback ? tx : rx;
            rxSync2 <= rxSync1;
            rxPrev  <= rxSync2;
        end
    end
    assign rxFall = rxPrev && !rxSync2;

    always_ff @(posedge clk) begin
        if (!rst) begin
            rxState <= RX_IDLE;
            rxTick  <= '0;
            rxBit   <= '0;
            rxShift <= '0;
`ifdef UART_MMIO_PARITY_EN
            rxPar   <= 1'b0;
`endif
        end else begin
            rxState <= rxStateN;
            rxTick  <= rxTickN;
            rxBit   <= rxBitN;
            rxShift <= rxShiftN;
`ifdef UART_MMIO_PARITY_EN
            rxPar   <= rxParN;
`endif
        end
    end

    // The stop bit is judged mid-bit and the FSM idles immediately, so the
    // next start edge can be caught during the remainder of the stop bit.
    always_comb begin
        rxStateN = rxState;
        rxTickN  = rxTick;
        rxBitN   = rxBit;
        rxShiftN = rxShift;
        rxValid  = 1'b0;
`ifdef UART_MMIO_PARITY_EN
        rxParN   = rxPar;
`endif
        if (rxState == RX_IDLE) begin
            if (rxFall) begin
                rxTickN  = '0;
                rxStateN = RX_START;
            end
        end else if (tick) begin
            rxTickN = rxTick + 4'd1;
            case (rxState)
                RX_START: begin
                    if (rxTick == 4'd7 && rxSync2) begin
                        rxStateN = RX_IDLE;
                    end else if (rxTick == 4'd15) begin
                        rxBitN   = '0;
                        rxStateN = RX_DATA;
                    end
                end
                RX_DATA: begin
                    if (rxTick == 4'd7) rxShiftN = {rxSync2, rxShift[DATA_W-1:1]};
                    if (rxTick == 4'd15) begin
                        rxBitN = rxBit + BIT_W'(1);
                        if (rxBit == LAST_BIT) begin
`ifdef UART_MMIO_PARITY_EN
                            rxStateN = RX_PARITY;
`else
                            rxStateN = RX_STOP;
`endif
                        end
                    end
                end
                RX_PARITY: begin
`ifdef UART_MMIO_PARITY_EN
                    if (rxTick == 4'd7) rxParN = rxSync2;
`endif
                    if (rxTick == 4'd15) rxStateN = RX_STOP;
                end
                default: begin
                    if (rxTick == 4'd7) begin
                        rxValid  = rxSync2;
                        rxStateN = RX_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_mmio_port.sv
// Directed self-checking bench for uart_mmio_port with an RX byte scoreboard;
// covers the UART_MMIO_PARITY_EN build when that macro is defined.
module tb_uart_mmio_port;
    import uart_mmio_pkg::*;

    localparam int unsigned CLK_FREQ = 6400000;
    localparam int unsigned BAUD     = 100000;
    localparam int unsigned BIT_CLKS = 64;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [1:0] addr = '0;
    logic       wr = 1'b0;
    logic       rd = 1'b0;
    logic [7:0] wdata = '0;
    logic [7:0] rdata;
    logic       rxLine = 1'b1;
    logic       tx;
    logic       irq;

    int passCnt = 0;
    int totalCnt = 0;
    logic [7:0] expQ[$];
`ifdef UART_MMIO_PARITY_EN
    logic badPar = 1'b0;
`endif

    uart_mmio_port #(
        .CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .DATA_W(8), .FIFO_DEPTH(16)
    ) dut (
        .clk(clk), .rst(rst), .addr(addr), .wr(wr), .rd(rd), .wdata(wdata),
        .rdata(rdata), .rx(rxLine), .tx(tx), .irq(irq)
    );

    always #5 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        totalCnt++;
        assert (obs === exp) begin
            passCnt++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic regWrite(input logic [1:0] a, input logic [7:0] d);
        @(negedge clk);
        addr = a; wdata = d; wr = 1'b1;
        @(negedge clk);
        wr = 1'b0;
    endtask

    task automatic regRead(input logic [1:0] a, output logic [7:0] d);
        @(negedge clk);
        addr = a; rd = 1'b1;
        @(negedge clk);
        rd = 1'b0;
        d = rdata;
    endtask

    task automatic sendFrame(input logic [7:0] d);
        @(negedge clk);
        rxLine = 1'b0;
        repeat (BIT_CLKS) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxLine = d[i];
            repeat (BIT_CLKS) @(negedge clk);
        end
`ifdef UART_MMIO_PARITY_EN
        rxLine = (^d) ^ badPar;
        repeat (BIT_CLKS) @(negedge clk);
`endif
        rxLine = 1'b1;
        repeat (BIT_CLKS) @(negedge clk);
    endtask

    task automatic waitTxFall(output logic ok);
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (tx === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Pops the scoreboard as bytes become readable; leftovers count as a failure.
    task automatic drainRx(input int budget);
        logic [7:0] s;
        logic [7:0] d;
        int cycles;
        cycles = 0;
        while (expQ.size() > 0 && cycles < budget) begin
            regRead(ADDR_STATUS, s);
            cycles += 2;
            if (!s[ST_RX_EMPTY]) begin
                regRead(ADDR_DATA, d);
                cycles += 2;
                check("rx_data", d, expQ.pop_front());
            end
        end
        check("drain_left", expQ.size(), 0);
        expQ.delete();
    endtask

    initial begin
        logic [7:0] s;
        logic [7:0] d;
        logic ok;
        logic busy;
        logic expBits[$];

        repeat (4) @(negedge clk);
        check("reset_tx", tx, 1'b1);
        check("reset_irq", irq, 1'b0);
        check("reset_rdata", rdata, 8'h00);
        rst = 1'b1;

        regRead(ADDR_STATUS, s); check("status_reset", s, 8'h01);
        regRead(ADDR_ID, s);     check("id", s, 8'h52);
        regRead(ADDR_CTRL, s);   check("ctrl_reset", s, 8'h00);
        regWrite(ADDR_CTRL, 8'hFF);
        regRead(ADDR_CTRL, s);   check("ctrl_mask", s, 8'h03);
        check("irq_rx_empty", irq, 1'b0);
        regWrite(ADDR_ID, 8'h00);
        regRead(ADDR_ID, s);     check("id_readonly", s, 8'h52);
        regWrite(ADDR_STATUS, 8'hFF);
        regRead(ADDR_STATUS, s); check("status_readonly", s, 8'h01);
        regRead(ADDR_DATA, s);   check("data_empty", s, 8'h00);

        // Loopback of 0xA5 with per-bit line checks.
        regWrite(ADDR_CTRL, 8'h03);
        d = 8'hA5;
        regWrite(ADDR_DATA, d);
        expQ.push_back(d);
        waitTxFall(ok);
        check("tx_start_seen", ok, 1'b1);
        expBits.push_back(1'b0);
        for (int i = 0; i < 8; i++) expBits.push_back(d[i]);
`ifdef UART_MMIO_PARITY_EN
        expBits.push_back(^d);
`endif
        expBits.push_back(1'b1);
        repeat (BIT_CLKS / 2) @(negedge clk);
        foreach (expBits[k]) begin
            check($sformatf("tx_bit%0d", k), tx, expBits[k]);
            repeat (BIT_CLKS) @(negedge clk);
        end
        busy = 1'b1;
        for (int i = 0; i < 100 && busy; i++) begin
            regRead(ADDR_STATUS, s);
            busy = s[ST_TX_BUSY];
        end
        check("tx_busy_fall", busy, 1'b0);
        check("status_after_tx", s, 8'h00);
        check("irq_set", irq, 1'b1);
        drainRx(200);
        check("irq_clear", irq, 1'b0);

        // TX FIFO fill while the line is occupied by the first frame.
        regWrite(ADDR_CTRL, 8'h02);
        regWrite(ADDR_DATA, 8'h11);
        expQ.push_back(8'h11);
        waitTxFall(ok);
        check("tx_start_fill", ok, 1'b1);
        for (int i = 0; i < 16; i++) begin
            regWrite(ADDR_DATA, 8'(8'h20 + i));
            expQ.push_back(8'(8'h20 + i));
        end
        regRead(ADDR_STATUS, s); check("tx_full_16", s, 8'h13);
        regWrite(ADDR_DATA, 8'hEE);
        regRead(ADDR_STATUS, s); check("tx_full_drop", s, 8'h13);
        drainRx(20000);
        repeat (800) @(negedge clk);
        regRead(ADDR_STATUS, s); check("status_after_fill", s, 8'h01);

        // Reset in the middle of a looped-back frame.
        regWrite(ADDR_DATA, 8'h3C);
        waitTxFall(ok);
        check("tx_start_abort", ok, 1'b1);
        repeat (100) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("abort_tx", tx, 1'b1);
        check("abort_irq", irq, 1'b0);
        rst = 1'b1;
        regRead(ADDR_STATUS, s); check("abort_status", s, 8'h01);
        regRead(ADDR_CTRL, s);   check("abort_ctrl", s, 8'h00);

        // RX overrun with 17 unread frames.
        for (int i = 0; i < 17; i++) begin
            d = 8'(i * 37 + 5);
            sendFrame(d);
            if (i < 16) expQ.push_back(d);
        end
        repeat (10) @(negedge clk);
        regRead(ADDR_STATUS, s); check("overrun_set", s, 8'h04);
        regRead(ADDR_STATUS, s); check("overrun_clr", s, 8'h00);
        drainRx(200);
        regRead(ADDR_STATUS, s); check("status_drained", s, 8'h01);

        // Start-bit glitch rejection with interrupts enabled.
        regWrite(ADDR_CTRL, 8'h01);
        @(negedge clk);
        rxLine = 1'b0;
        repeat (16) @(negedge clk);
        rxLine = 1'b1;
        repeat (200) @(negedge clk);
        check("glitch_irq", irq, 1'b0);
        regRead(ADDR_STATUS, s); check("glitch_status", s, 8'h01);
        sendFrame(8'h5A);
        expQ.push_back(8'h5A);
        repeat (10) @(negedge clk);
        check("rx_irq", irq, 1'b1);
        drainRx(200);
        check("rx_irq_clr", irq, 1'b0);

`ifdef UART_MMIO_PARITY_EN
        badPar = 1'b1;
        sendFrame(8'h03);
        badPar = 1'b0;
        expQ.push_back(8'h03);
        repeat (10) @(negedge clk);
        regRead(ADDR_STATUS, s); check("parity_set", s, 8'h08);
        regRead(ADDR_STATUS, s); check("parity_clr", s, 8'h00);
        drainRx(200);
        regRead(ADDR_STATUS, s); check("parity_final", s, 8'h01);
`endif

        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule
